elink_tx_arbiter: RTL and testbench
===================================

# elink_tx_arbiter

Shares one downstream 32-bit elink transmit stream between up to N_REQ upstream AXI-Stream sources (fast commands, slow control, test pattern). Grants the link one packet (burst) at a time in round-robin order, with optional strict priority for requester 0. Fills unused link slots with a fixed idle word so the serialiser never starves. Sits directly upstream of the 32→8 elink width adapter in the 160 MHz domain.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, word width of every stream
- MAX_BURST, 16, maximum words per grant before forced re-arbitration (≥1)
- PRIO0, 0, 1 = requester 0 wins every arbitration when valid
- IDLE_WORD, 32'hACCC_CCCC, filler word emitted when no grant is active

Ports:
- clk160  in  1  sole clock
- clk160_areset  in  1  asynchronous, active-high reset
- S_AXIS_tdata  in  N_REQ*DATA_WIDTH  requester words; requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- S_AXIS_tvalid  in  N_REQ  per-requester valid
- S_AXIS_tlast  in  N_REQ  per-requester end of packet
- S_AXIS_tready  out  N_REQ  per-requester ready
- M_AXIS_tdata  out  DATA_WIDTH  word to adapter
- M_AXIS_tvalid  out  1  output valid
- M_AXIS_tready  in  1  adapter ready
- idle_en  in  1  1 = emit IDLE_WORD when no grant; 0 = M_AXIS_tvalid low when no grant
- grant_id  out  $clog2(N_REQ)  index of current/last granted requester
- grant_active  out  1  high while in GRANT

## Operation
- States: ARB, GRANT.
- ARB: S_AXIS_tready all 0; M_AXIS_tvalid = idle_en; M_AXIS_tdata = IDLE_WORD.
- Pick: if PRIO0=1 and tvalid[0], pick 0; else first i with tvalid[i] searching from (last_grant+1) mod N_REQ upward with wrap.
- ARB → GRANT when any tvalid is high AND no idle word pending (idle_en=0 or M_AXIS_tready=1 this cycle). Registers grant_id = pick, clears burst_cnt.
- GRANT(g): M_AXIS_tdata/tvalid = requester g's; S_AXIS_tready[g] = M_AXIS_tready; others 0.
- On each beat (tvalid[g] & M_AXIS_tready): burst_cnt++. GRANT → ARB when beat has tlast[g]=1 or burst_cnt reaches MAX_BURST-1 (i.e. MAX_BURST-th beat). last_grant = g on exit.
- tvalid[g] deasserting mid-packet: stay in GRANT, M_AXIS_tvalid low; no idle word inserted inside a packet.
- Requester tdata/tlast are passed unmodified; no buffering.
- burst_cnt width $clog2(MAX_BURST+1); never wraps (exit at limit).

## Timing
- Reset (asynchronous assert, synchronous-release by system): state ARB, grant_id 0, last_grant N_REQ-1 (so requester 0 is first in RR), burst_cnt 0, grant_active 0, S_AXIS_tready 0, M_AXIS_tvalid = idle_en, M_AXIS_tdata IDLE_WORD.
- Arbitration latency: 1 cycle from decision to first data presented; minimum 1 ARB cycle between consecutive grants (one idle word if idle_en and M_AXIS_tready).
- Output path combinational mux from registered grant; zero added latency in GRANT.
- AXI-Stream rules: idle word, once valid, held until accepted (never withdrawn for data). Requester tvalid may rise in ARB without affecting output that cycle.
- Single-beat packet (tlast on first beat): GRANT lasts exactly one accepting cycle.
- Reset mid-packet: packet abandoned, requester sees tready drop immediately.

## Structure
- Package elink_pkg: arbiter state enum (ARB, GRANT), default IDLE_WORD constant.
- Sub-module rr_pick: combinational round-robin selector (req vector, last index, prio0 → pick index, any).
- Top: state register, burst counter, output mux.

## Test plan
- Single requester 1 sends 3-word packet 0x11111111..0x33333333 with tlast on 3rd, M ready always, idle_en=1 → output: IDLE, 0x11111111, 0x22222222, 0x33333333, IDLE; grant_id=1.
- All 4 requesters continuously valid, 2-word packets, PRIO0=0 → grant order 0,1,2,3,0 with one IDLE between packets.
- PRIO0=1, requesters 0 and 2 always valid → every grant goes to 0; requester 2 never granted.
- Requester 3 streams 40 words no tlast, MAX_BURST=16 → grant breaks after beats 16 and 32; requester 3 regranted when alone.
- M_AXIS_tready held low 5 cycles while IDLE valid and requester 1 asserts valid → IDLE_WORD held stable, grant only after idle accepted.
- Assert clk160_areset mid-packet → S_AXIS_tready all 0, grant_active 0 same cycle; after release requester 0 wins first arbitration.

Source files
------------

// File: rtl/elink_pkg.sv
// Shared types and constants for the elink transmit arbiter.
package elink_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam logic [31:0] IDLE_WORD_DEFAULT = 32'hACCC_CCCC;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector with optional strict priority for index 0.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   last_i,
    input  logic             prio0_i,
    output logic [IDW-1:0]   pick_o,
    output logic             any_o
);

    logic [IDW-1:0] idx;

    // Walk candidates from farthest to nearest so the nearest match after last_i wins.
    always_comb begin
        pick_o = '0;
        idx    = '0;
        any_o  = |req_i;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            idx = IDW'((int'(last_i) + k) % int'(N_REQ));
            if (req_i[idx]) begin
                pick_o = idx;
            end
        end
        if (prio0_i && req_i[0]) begin
            pick_o = '0;
        end
    end

endmodule

// File: rtl/elink_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the 32-bit elink transmit stream,
// with idle-word fill between grants.
module elink_tx_arbiter
    import elink_pkg::*;
#(
    parameter int unsigned           N_REQ      = 4,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MAX_BURST  = 16,
    parameter bit                    PRIO0      = 1'b0,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = DATA_WIDTH'(IDLE_WORD_DEFAULT)
) (
    input  logic                        clk160,
    input  logic                        clk160_areset,
    input  logic [N_REQ*DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic [N_REQ-1:0]            S_AXIS_tvalid,
    input  logic [N_REQ-1:0]            S_AXIS_tlast,
    output logic [N_REQ-1:0]            S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]       M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    input  logic                        idle_en,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        grant_active
);

    localparam int unsigned IDW = $clog2(N_REQ);
    localparam int unsigned BCW = $clog2(MAX_BURST + 1);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [BCW-1:0]  burst_q, burst_d;
    logic [IDW-1:0]  pick;
    logic            any_req;

    logic [DATA_WIDTH-1:0] req_data [N_REQ];

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_unpack
        assign req_data[i] = S_AXIS_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .req_i   (S_AXIS_tvalid),
        .last_i  (last_q),
        .prio0_i (PRIO0),
        .pick_o  (pick),
        .any_o   (any_req)
    );

    always_ff @(posedge clk160 or posedge clk160_areset) begin
        if (clk160_areset) begin
            state_q <= ST_ARB;
            grant_q <= '0;
            last_q  <= IDW'(N_REQ - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    // Grant is only taken once any pending idle word has been accepted.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        burst_d       = burst_q;
        S_AXIS_tready = '0;
        M_AXIS_tvalid = idle_en;
        M_AXIS_tdata  = IDLE_WORD;
        case (state_q)
            ST_ARB: begin
                if (any_req && (!idle_en || M_AXIS_tready)) begin
                    state_d = ST_GRANT;
                    grant_d = pick;
                    burst_d = '0;
                end
            end
            ST_GRANT: begin
                M_AXIS_tdata           = req_data[grant_q];
                M_AXIS_tvalid          = S_AXIS_tvalid[grant_q];
                S_AXIS_tready[grant_q] = M_AXIS_tready;
                if (S_AXIS_tvalid[grant_q] && M_AXIS_tready) begin
                    if (S_AXIS_tlast[grant_q] || (burst_q == BCW'(MAX_BURST - 1))) begin
                        state_d = ST_ARB;
                        last_d  = grant_q;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + BCW'(1);
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    assign grant_id     = grant_q;
    assign grant_active = (state_q == ST_GRANT);

endmodule

// File: tb/tb_elink_tx_arbiter.sv
// Directed bench for elink_tx_arbiter: round-robin, priority, burst limit, idle hold, reset.
`timescale 1ns/1ps
module tb_elink_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam logic [31:0] IDLE = 32'hACCC_CCCC;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready, s_tready_p;
    logic [DW-1:0]   m_tdata, m_tdata_p;
    logic            m_tvalid, m_tvalid_p, m_tready, idle_en;
    logic [1:0]      gid, gid_p;
    logic            gact, gact_p;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt [N];
    int k;
    int w;
    logic [N-1:0] rdy;

    always #5 clk = ~clk;

    elink_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(16), .PRIO0(1'b0)) dut (
        .clk160        (clk),
        .clk160_areset (rst),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tlast  (s_tlast),
        .S_AXIS_tready (s_tready),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tready (m_tready),
        .idle_en       (idle_en),
        .grant_id      (gid),
        .grant_active  (gact)
    );

    elink_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(16), .PRIO0(1'b1)) dut_p (
        .clk160        (clk),
        .clk160_areset (rst),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tlast  (s_tlast),
        .S_AXIS_tready (s_tready_p),
        .M_AXIS_tdata  (m_tdata_p),
        .M_AXIS_tvalid (m_tvalid_p),
        .M_AXIS_tready (m_tready),
        .idle_en       (idle_en),
        .grant_id      (gid_p),
        .grant_active  (gact_p)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        idle_en  = 1'b1;
        #1;
        chk("rst_gact",   32'(gact),     32'd0);
        chk("rst_gid",    32'(gid),      32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd1);
        chk("rst_tdata",  m_tdata,       IDLE);
        idle_en = 1'b0;
        #1;
        chk("rst_noidle_tvalid", 32'(m_tvalid), 32'd0);
        idle_en = 1'b1;
        do_reset();

        // Single 3-word packet from requester 1
        s_tvalid = 4'b0010;
        s_tdata[1*DW +: DW] = 32'h1111_1111;
        #1;
        chk("p1_arb_tdata", m_tdata,   IDLE);
        chk("p1_arb_gact",  32'(gact), 32'd0);
        tick();
        chk("p1_w0_tdata",  m_tdata,       32'h1111_1111);
        chk("p1_w0_gid",    32'(gid),      32'd1);
        chk("p1_w0_tready", 32'(s_tready), 32'b0010);
        tick();
        s_tdata[1*DW +: DW] = 32'h2222_2222;
        #1;
        chk("p1_w1_tdata", m_tdata, 32'h2222_2222);
        tick();
        s_tdata[1*DW +: DW] = 32'h3333_3333;
        s_tlast = 4'b0010;
        #1;
        chk("p1_w2_tdata", m_tdata, 32'h3333_3333);
        tick();
        s_tvalid = '0;
        s_tlast  = '0;
        #1;
        chk("p1_end_tdata", m_tdata,   IDLE);
        chk("p1_end_gact",  32'(gact), 32'd0);
        chk("p1_end_gid",   32'(gid),  32'd1);

        // All four requesters streaming 2-word packets, plain round-robin
        do_reset();
        s_tvalid = '1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 15; c++) begin
            for (int i = 0; i < N; i++) begin
                s_tdata[i*DW +: DW] = {4'(i), 27'd0, 1'(cnt[i])};
                s_tlast[i] = (cnt[i] == 1);
            end
            #1;
            if (c % 3 == 0) begin
                chk("rr_idle_gact",  32'(gact), 32'd0);
                chk("rr_idle_tdata", m_tdata,   IDLE);
            end else begin
                chk("rr_gid",   32'(gid),  32'((c / 3) % 4));
                chk("rr_gact",  32'(gact), 32'd1);
                chk("rr_tdata", m_tdata,   {4'((c / 3) % 4), 27'd0, 1'((c % 3) - 1)});
            end
            rdy = s_tready;
            tick();
            for (int i = 0; i < N; i++) if (rdy[i]) cnt[i] = 1 - cnt[i];
        end

        // Strict priority: requesters 0 and 2 valid, only 0 is ever granted
        do_reset();
        s_tvalid = 4'b0101;
        s_tlast  = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 15; c++) begin
            for (int i = 0; i < N; i++) begin
                s_tdata[i*DW +: DW] = {4'(i), 27'd0, 1'(cnt[i])};
                s_tlast[i] = (cnt[i] == 1);
            end
            #1;
            chk("pr_req2_tready", 32'(s_tready_p[2]), 32'd0);
            if (c % 3 == 0) begin
                chk("pr_idle_gact", 32'(gact_p), 32'd0);
                chk("pr_idle_tdata", m_tdata_p, IDLE);
            end else begin
                chk("pr_gid",   32'(gid_p),  32'd0);
                chk("pr_gact",  32'(gact_p), 32'd1);
                chk("pr_tdata", m_tdata_p,   {4'd0, 27'd0, 1'((c % 3) - 1)});
            end
            rdy = s_tready_p;
            tick();
            for (int i = 0; i < N; i++) if (rdy[i]) cnt[i] = 1 - cnt[i];
        end

        // Requester 3 streams 40 words without tlast; bursts cut at 16 beats
        do_reset();
        s_tvalid = 4'b1000;
        s_tlast  = '0;
        k = 0;
        for (int c = 0; c < 43; c++) begin
            s_tdata[3*DW +: DW] = 32'(k);
            #1;
            if (c == 0 || c == 17 || c == 34) begin
                chk("bl_idle_gact",  32'(gact), 32'd0);
                chk("bl_idle_tdata", m_tdata,   IDLE);
            end else begin
                w = c - 1 - ((c > 17) ? 1 : 0) - ((c > 34) ? 1 : 0);
                chk("bl_gid",   32'(gid), 32'd3);
                chk("bl_tdata", m_tdata,  32'(w));
            end
            rdy = s_tready;
            tick();
            if (rdy[3]) k++;
        end
        chk("bl_beats", 32'(k), 32'd40);
        s_tvalid = '0;
        #1;
        chk("bl_gap_gact",   32'(gact),     32'd1);
        chk("bl_gap_tvalid", 32'(m_tvalid), 32'd0);

        // Idle word held while downstream stalls; grant only after acceptance
        do_reset();
        m_tready = 1'b0;
        s_tvalid = 4'b0010;
        s_tlast  = 4'b0010;
        s_tdata[1*DW +: DW] = 32'hBEEF_0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("st_tvalid", 32'(m_tvalid), 32'd1);
            chk("st_tdata",  m_tdata,       IDLE);
            chk("st_gact",   32'(gact),     32'd0);
            chk("st_tready", 32'(s_tready), 32'd0);
            tick();
        end
        m_tready = 1'b1;
        #1;
        chk("st_acc_gact",  32'(gact), 32'd0);
        chk("st_acc_tdata", m_tdata,   IDLE);
        tick();
        chk("st_g_gact",   32'(gact),     32'd1);
        chk("st_g_gid",    32'(gid),      32'd1);
        chk("st_g_tdata",  m_tdata,       32'hBEEF_0001);
        chk("st_g_tready", 32'(s_tready), 32'b0010);
        tick();
        s_tvalid = '0;
        s_tlast  = '0;

        // Reset in the middle of a packet
        do_reset();
        s_tvalid = 4'b0100;
        s_tdata[2*DW +: DW] = 32'h0000_C0DE;
        #1;
        chk("rm_arb_gact", 32'(gact), 32'd0);
        tick();
        chk("rm_g_gid",    32'(gid),      32'd2);
        chk("rm_g_tready", 32'(s_tready), 32'b0100);
        tick();
        rst = 1'b1;
        #1;
        chk("rm_rst_tready", 32'(s_tready), 32'd0);
        chk("rm_rst_gact",   32'(gact),     32'd0);
        chk("rm_rst_tdata",  m_tdata,       IDLE);
        tick();
        rst = 1'b0;
        s_tvalid = 4'b0101;
        s_tdata[0*DW +: DW] = 32'h0000_00D0;
        #1;
        chk("rm_rel_gact", 32'(gact), 32'd0);
        tick();
        chk("rm_first_gid",   32'(gid),  32'd0);
        chk("rm_first_gact",  32'(gact), 32'd1);
        chk("rm_first_tdata", m_tdata,   32'h0000_00D0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
